bludger_ver_controller: RTL

BLUDGER_VER_CONTROLLER -- requirements
Module: bludger_ver_controller

---
 rtl/bludger_ver_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bludger_ver_controller.sv
// rtl/bludger_ver_controller.sv - vertical bludger ball motion with wall and player bounces
module bludger_ver_controller #(
  parameter int BALL_RADIUS     = 25,
  parameter int BALL_X          = 400,
  parameter int INITIAL_VER_POS = 275,
  parameter int TOP_BOUND       = 35,
  parameter int BOTTOM_BOUND    = 515,
  parameter int MOVE_PERIOD     = 200000,
  parameter int PAUSE_STEPS     = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [9:0] player_hor_pos,
  input  logic [9:0] player_ver_pos,
  output logic [9:0] ball_y,
  output logic       ball_dir,
  output logic       bounce
);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_DOWN  = 2'd1;
  localparam logic [1:0] S_UP    = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int PW = (PAUSE_STEPS > 0) ? $clog2(PAUSE_STEPS + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(MOVE_PERIOD - 1);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_STEPS);
  localparam logic [21:0]   HIT_R2     = 22'((2 * BALL_RADIUS + 2) * (2 * BALL_RADIUS + 2));
  // Centre-row limits: the ball edge touches a wall once the centre reaches these.
  localparam logic [10:0]   BOT_LIM    = 11'(BOTTOM_BOUND - BALL_RADIUS);
  localparam logic [10:0]   TOP_LIM    = 11'(TOP_BOUND + BALL_RADIUS);

  logic [1:0]        state;
  logic [CW-1:0]     step_cnt;
  logic [PW-1:0]     pause_cnt;
  logic              step;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [9:0]        adx;
  logic [9:0]        ady;
  logic [19:0]       dx2;
  logic [19:0]       dy2;
  logic [21:0]       dist2;
  logic              hit;
  logic              at_bottom;
  logic              at_top;

  assign step = enable && (step_cnt == CNT_LAST);

  // Squared player-to-ball distance on magnitudes so the sum stays unsigned and overflow-free.
  always_comb begin
    dx    = $signed({1'b0, player_hor_pos}) - $signed(11'(BALL_X));
    dy    = $signed({1'b0, player_ver_pos}) - $signed({1'b0, ball_y});
    adx   = dx[10] ? 10'(-dx) : 10'(dx);
    ady   = dy[10] ? 10'(-dy) : 10'(dy);
    dx2   = adx * adx;
    dy2   = ady * ady;
    dist2 = 22'(dx2) + 22'(dy2);
    hit   = dist2 < HIT_R2;
    at_bottom = {1'b0, ball_y} >= BOT_LIM;
    at_top    = {1'b0, ball_y} <= TOP_LIM;
  end

  // Free-running step timer that freezes while the ball is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (enable) begin
      step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

  // Motion FSM: player hits win over wall hits, and both keep ball_y for the reversal step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      ball_y    <= 10'(INITIAL_VER_POS);
      ball_dir  <= 1'b1;
      bounce    <= 1'b0;
      pause_cnt <= '0;
    end else begin
      bounce <= 1'b0;
      if (!enable) begin
        state <= S_HOLD;
      end else begin
        case (state)
          S_HOLD: state <= ball_dir ? S_DOWN : S_UP;
          S_DOWN: begin
            if (step) begin
              if (hit && (player_ver_pos > ball_y)) begin
                ball_dir  <= 1'b0;
                bounce    <= 1'b1;
                pause_cnt <= PAUSE_LOAD;
                state     <= S_PAUSE;
              end else if (at_bottom) begin
                ball_dir <= 1'b0;
                bounce   <= 1'b1;
                state    <= S_UP;
              end else begin
                ball_y <= ball_y + 10'd1;
              end
            end
          end
          S_UP: begin
            if (step) begin
              if (hit && (player_ver_pos < ball_y)) begin
                ball_dir  <= 1'b1;
                bounce    <= 1'b1;
                pause_cnt <= PAUSE_LOAD;
                state     <= S_PAUSE;
              end else if (at_top) begin
                ball_dir <= 1'b1;
                bounce   <= 1'b1;
                state    <= S_DOWN;
              end else begin
                ball_y <= ball_y - 10'd1;
              end
            end
          end
          default: begin
            if (step) begin
              if (pause_cnt <= PW'(1)) begin
                pause_cnt <= '0;
                state     <= ball_dir ? S_DOWN : S_UP;
              end else begin
                pause_cnt <= pause_cnt - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
